// File: rtl/nios2_secure_memory_zeroizer.sv
// Zeroization engine: an Avalon-MM master on RAM port s2 that overwrites every word
// with PATTERN and then, optionally, reads every word back and checks it.
// Ports: clk, reset (sync, active-high), start/tamper requests, busy/done/fail/fail_addr
// status, and the mem_* Avalon-MM master signals (readdata valid 1 cycle after a read).
module nios2_secure_memory_zeroizer #(
  parameter int              DEPTH   = 5120,
  parameter int              ADDR_W  = 13,
  parameter int              DATA_W  = 32,
  parameter logic [DATA_W-1:0] PATTERN = '0,
  parameter bit              VERIFY  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                tamper,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIPE,
    S_VERIFY,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic                pend_valid;
  logic [ADDR_W-1:0]   pend_addr;
  logic                idle_like;
  logic                trig;

  // A start is only honoured outside a run; tamper restarts from anywhere.
  assign idle_like = (state == S_IDLE) ||
                     (state == S_DONE) ||
                     (state == S_FAIL);
  assign trig      = tamper | (start & idle_like);

  assign mem_byteenable = {(DATA_W/8){mem_chipselect}};
  assign mem_writedata  = PATTERN;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      fail_addr      <= '0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      pend_valid     <= 1'b0;
      pend_addr      <= '0;
    end else if (trig) begin
      // New run; any compare still in flight is dropped.
      state          <= S_WIPE;
      busy           <= 1'b1;
      done           <= 1'b0;
      fail           <= 1'b0;
      fail_addr      <= '0;
      mem_address    <= '0;
      mem_chipselect <= 1'b1;
      mem_write      <= 1'b1;
      pend_valid     <= 1'b0;
    end else begin
      unique case (state)
        S_WIPE: begin
          if (mem_address == LAST) begin
            mem_address <= '0;
            mem_write   <= 1'b0;
            if (VERIFY) begin
              state <= S_VERIFY;
            end else begin
              state          <= S_DONE;
              done           <= 1'b1;
              busy           <= 1'b0;
              mem_chipselect <= 1'b0;
            end
          end else begin
            mem_address <= mem_address + ADDR_W'(1);
          end
        end
        S_VERIFY: begin
          // Word read last cycle is on mem_readdata now.
          pend_valid <= mem_chipselect;
          pend_addr  <= mem_address;
          if (pend_valid && (mem_readdata != PATTERN)) begin
            state          <= S_FAIL;
            fail           <= 1'b1;
            fail_addr      <= pend_addr;
            busy           <= 1'b0;
            mem_chipselect <= 1'b0;
            pend_valid     <= 1'b0;
          end else if (mem_chipselect) begin
            // Hold the counter at the last word; the next cycle drains.
            if (mem_address == LAST) begin
              mem_chipselect <= 1'b0;
            end else begin
              mem_address <= mem_address + ADDR_W'(1);
            end
          end else begin
            state      <= S_DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            pend_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_secure_memory_zeroizer.sv
// Self-checking bench for nios2_secure_memory_zeroizer.
// Drives a behavioural RAM on s2 and compares against a cycle-position model.
module tb_nios2_secure_memory_zeroizer;

  localparam int D   = 5120;
  localparam int AW  = 13;
  localparam int SD  = 16;
  localparam int SAW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic tamper = 1'b0;
  logic start2 = 1'b0;
  logic tamper2 = 1'b0;

  logic          busy, done, fail;
  logic [AW-1:0] fail_addr, mem_address;
  logic          cs, wr, clken;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rd = '0;

  logic           s_busy, s_done, s_fail;
  logic [SAW-1:0] s_fail_addr, s_addr;
  logic           s_cs, s_wr, s_clken;
  logic [3:0]     s_be;
  logic [31:0]    s_wd;
  logic [31:0]    s_rd = 32'hFFFF_FFFF;

  int checks = 0;
  int failures = 0;
  int seq_bad = 0;
  int first_k = 0;
  int oob = 0;
  int s_reads = 0;

  logic [31:0] ram [D];
  logic        fault_en = 1'b0;
  int          fault_addr = 0;

  always #5 clk = ~clk;

  nios2_secure_memory_zeroizer u_dut (
    .clk(clk), .reset(reset), .start(start), .tamper(tamper),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .mem_address(mem_address), .mem_chipselect(cs), .mem_write(wr),
    .mem_byteenable(be), .mem_writedata(wd), .mem_clken(clken),
    .mem_readdata(rd)
  );

  nios2_secure_memory_zeroizer #(
    .DEPTH(SD), .ADDR_W(SAW), .VERIFY(1'b0)
  ) u_small (
    .clk(clk), .reset(reset), .start(start2), .tamper(tamper2),
    .busy(s_busy), .done(s_done), .fail(s_fail), .fail_addr(s_fail_addr),
    .mem_address(s_addr), .mem_chipselect(s_cs), .mem_write(s_wr),
    .mem_byteenable(s_be), .mem_writedata(s_wd), .mem_clken(s_clken),
    .mem_readdata(s_rd)
  );

  // Synchronous RAM: inputs registered, readdata one cycle later.
  always @(posedge clk) begin
    if (cs && clken) begin
      if (int'(mem_address) >= D) begin
        oob <= oob + 1;
      end else if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ram[mem_address][8*b +: 8] <= wd[8*b +: 8];
      end else begin
        rd <= (fault_en && int'(mem_address) == fault_addr) ?
              32'h1 : ram[mem_address];
      end
    end
  end

  always @(posedge clk)
    if (s_cs && !s_wr) s_reads <= s_reads + 1;

  // Expected {busy,done,fail,cs,wr} and address k cycles after the start edge.
  function automatic void model(input int k, input int d, input bit ver,
                                output logic [4:0] e, output int ea);
    ea = -1;
    if (k < d) begin
      e = 5'b10011; ea = k;
    end else if (ver && k < 2*d) begin
      e = 5'b10010; ea = k - d;
    end else if (ver && k == 2*d) begin
      e = 5'b10000;
    end else begin
      e = 5'b01000;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk cycles k0..k1-1 of a run, tallying deviations from the model.
  task automatic track(input int k0, input int k1);
    logic [4:0] e;
    int ea;
    for (int k = k0; k < k1; k++) begin
      model(k, D, 1'b1, e, ea);
      if ({busy, done, fail, cs, wr} !== e ||
          (ea >= 0 && int'(mem_address) != ea) ||
          (cs && be !== 4'hF) || (wr && wd !== 32'h0)) begin
        if (seq_bad == 0) first_k = k;
        seq_bad++;
      end
      step();
    end
  endtask

  task automatic preload(input bit rnd);
    for (int i = 0; i < D; i++)
      ram[i] = rnd ? ($urandom | 32'h1) : 32'hDEAD_BEEF;
  endtask

  function automatic int count_nonzero();
    int n = 0;
    for (int i = 0; i < D; i++)
      if (ram[i] !== 32'h0) n++;
    return n;
  endfunction

  task automatic pulse_start(input bit with_tamper);
    start = 1'b1;
    tamper = with_tamper;
    step();
    start = 1'b0;
    tamper = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({busy, done, fail, cs, wr} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {busy, done, fail, cs, wr});
    end
    checks++;
    if (mem_address !== '0 || fail_addr !== '0) begin
      failures++;
      $display("FAIL reset_addr got addr=%h fail_addr=%h exp 0", mem_address, fail_addr);
    end
    checks++;
    if ({s_busy, s_done, s_cs, s_wr} !== 4'b0 || clken !== 1'b1) begin
      failures++;
      $display("FAIL reset_misc got small=%b clken=%b", {s_busy, s_done, s_cs, s_wr}, clken);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_wipe_verify();
    bit both;
    int nz;
    preload(1'b0);
    repeat ($urandom_range(1, 5)) step();
    both = 1'($urandom_range(0, 1));
    seq_bad = 0;
    pulse_start(both);
    track(0, 2*D + 1);
    checks++;
    if (seq_bad !== 0) begin
      failures++;
      $display("FAIL wv_seq got %0d bad cycles (first k=%0d) exp 0", seq_bad, first_k);
    end
    checks++;
    if ({busy, done, fail, cs} !== 4'b0100) begin
      failures++;
      $display("FAIL wv_done got=%b exp=0100", {busy, done, fail, cs});
    end
    nz = count_nonzero();
    checks++;
    if (nz !== 0) begin
      failures++;
      $display("FAIL wv_wiped got %0d nonzero words exp 0", nz);
    end
    step();
    checks++;
    if (done !== 1'b1 || oob !== 0) begin
      failures++;
      $display("FAIL wv_sticky got done=%b oob=%0d exp 1/0", done, oob);
    end
  endtask

  task automatic run_fail(input int f);
    preload(1'b1);
    fault_en = 1'b1;
    fault_addr = f;
    seq_bad = 0;
    pulse_start(1'b0);
    track(0, D + f + 2);
    checks++;
    if (seq_bad !== 0) begin
      failures++;
      $display("FAIL fail_seq f=%0d got %0d bad (first k=%0d) exp 0", f, seq_bad, first_k);
    end
    checks++;
    if ({busy, done, fail, cs, wr} !== 5'b00100) begin
      failures++;
      $display("FAIL fail_flags f=%0d got=%b exp=00100", f, {busy, done, fail, cs, wr});
    end
    checks++;
    if (int'(fail_addr) != f) begin
      failures++;
      $display("FAIL fail_addr got=%h exp=%h", fail_addr, f);
    end
    step();
    checks++;
    if (fail !== 1'b1 || cs !== 1'b0) begin
      failures++;
      $display("FAIL fail_sticky got fail=%b cs=%b exp 1/0", fail, cs);
    end
  endtask

  task automatic test_fail();
    run_fail(32'h0A5);
    run_fail(int'($urandom_range(0, D - 1)));
  endtask

  task automatic test_tamper();
    int r;
    fault_en = 1'b1;
    fault_addr = 99;
    seq_bad = 0;
    pulse_start(1'b0);
    checks++;
    if (fail !== 1'b0 || fail_addr !== '0) begin
      failures++;
      $display("FAIL tamper_clear got fail=%b fail_addr=%h exp 0/0", fail, fail_addr);
    end
    track(0, D + 100);
    checks++;
    if (int'(mem_address) != 100 || cs !== 1'b1 || wr !== 1'b0) begin
      failures++;
      $display("FAIL tamper_point got addr=%0d cs=%b wr=%b exp 100/1/0", mem_address, cs, wr);
    end
    tamper = 1'b1;
    step();
    tamper = 1'b0;
    fault_en = 1'b0;
    checks++;
    if (mem_address !== '0 || cs !== 1'b1 || wr !== 1'b1 || fail !== 1'b0) begin
      failures++;
      $display("FAIL tamper_restart got addr=%0d cs=%b wr=%b fail=%b", mem_address, cs, wr, fail);
    end
    track(0, 2*D + 1);
    r = int'($urandom_range(1, D - 1));
    pulse_start(1'b0);
    track(0, r);
    tamper = 1'b1;
    step();
    tamper = 1'b0;
    track(0, 2*D + 1);
    checks++;
    if (seq_bad !== 0 || done !== 1'b1 || fail !== 1'b0) begin
      failures++;
      $display("FAIL tamper_run got bad=%0d (k=%0d) done=%b fail=%b", seq_bad, first_k, done, fail);
    end
  endtask

  task automatic test_start_while_busy();
    int r;
    seq_bad = 0;
    pulse_start(1'b0);
    track(0, 50);
    checks++;
    if (int'(mem_address) != 50 || wr !== 1'b1) begin
      failures++;
      $display("FAIL busy_point got addr=%0d wr=%b exp 50/1", mem_address, wr);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    r = int'($urandom_range(D, 2*D - 1));
    track(51, r);
    start = 1'b1;
    step();
    start = 1'b0;
    track(r + 1, 2*D + 1);
    checks++;
    if (seq_bad !== 0 || done !== 1'b1) begin
      failures++;
      $display("FAIL busy_ignore got bad=%0d (k=%0d) done=%b", seq_bad, first_k, done);
    end
  endtask

  task automatic test_reset_mid_run();
    preload(1'b0);
    pulse_start(1'b0);
    track(0, 2000);
    reset = 1'b1;
    step();
    checks++;
    if ({busy, cs, wr, done, fail} !== 5'b0 || mem_address !== '0) begin
      failures++;
      $display("FAIL rst_mid got=%b addr=%0d exp 00000/0", {busy, cs, wr, done, fail}, mem_address);
    end
    checks++;
    if (ram[1999] !== 32'h0 || ram[2001] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rst_ram got 1999=%h 2001=%h", ram[1999], ram[2001]);
    end
    reset = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || cs !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle got busy=%b cs=%b exp 0/0", busy, cs);
    end
  endtask

  task automatic test_no_verify();
    logic [4:0] e;
    int ea;
    int bad = 0;
    int base = s_reads;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int k = 0; k < SD + 3; k++) begin
      model(k, SD, 1'b0, e, ea);
      if ({s_busy, s_done, s_fail, s_cs, s_wr} !== e ||
          (ea >= 0 && int'(s_addr) != ea)) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL nv_seq got %0d bad cycles exp 0", bad);
    end
    checks++;
    if (s_reads - base !== 0 || s_done !== 1'b1) begin
      failures++;
      $display("FAIL nv_reads got reads=%0d done=%b exp 0/1", s_reads - base, s_done);
    end
  endtask

  initial begin
    test_reset();
    test_wipe_verify();
    test_fail();
    test_tamper();
    test_start_while_busy();
    test_reset_mid_run();
    test_no_verify();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
